arcfour_search_scheduler: RTL and testbench

- Parallel key-search scheduler sitting above NUM_CORES arcfour cores, each with its own S/K/A memories.
- Statically splits the 2^KEY_BITS key space into equal contiguous slices, one per core, and launches all cores together.
- Monitors per-core terminated/succeeded pulses; latches the first successful key and reports an aggregate result plus a cycle count.
- On success, kills the remaining cores.

---
 rtl/arcfour_sched_pkg.sv | 12 +
 rtl/sched_priority_encoder.sv | 15 +
 rtl/arcfour_search_scheduler.sv | 94 +++++++++
 tb/tb_arcfour_search_scheduler.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/arcfour_sched_pkg.sv
// arcfour_sched_pkg: shared state encoding, defaults and key-slice arithmetic
// for the arcfour key-search scheduler.
package arcfour_sched_pkg;
    localparam int DEF_NUM_CORES = 4;
    localparam int DEF_KEY_BITS = 22;
    typedef enum logic [2:0] {IDLE, CLEAR, LAUNCH, RUN, KILL, FINISH} sched_state_t;
    // Start of slice idx; evaluated wide so the bound past the last slice stays exact.
    function automatic logic [63:0] slice_bound(input int unsigned idx, input int unsigned key_bits,
                                                input int unsigned num_cores);
        return (64'(idx) << key_bits) / 64'(num_cores);
    endfunction
endpackage

// File: rtl/sched_priority_encoder.sv
// sched_priority_encoder: lowest set index of a request vector plus a valid flag.
module sched_priority_encoder #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         valid
);
    always_comb begin
        idx = '0;
        for (int j = N - 1; j >= 0; j--) idx = req[j] ? W'(j) : idx;
        valid = |req;
    end
endmodule

// File: rtl/arcfour_search_scheduler.sv
// arcfour_search_scheduler: splits the key space across arcfour cores, launches them,
// and latches the first successful key with the elapsed cycle count.
module arcfour_search_scheduler
    import arcfour_sched_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int KEY_BITS = DEF_KEY_BITS,
    parameter int CNT_WIDTH = 32,
    localparam int WW = $clog2(NUM_CORES)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic [NUM_CORES-1:0]          core_reset,
    output logic [NUM_CORES-1:0]          core_start,
    output logic [NUM_CORES*KEY_BITS-1:0] core_lower,
    output logic [NUM_CORES*KEY_BITS-1:0] core_upper,
    input  logic [NUM_CORES-1:0]          core_terminated,
    input  logic [NUM_CORES-1:0]          core_succeeded,
    input  logic [NUM_CORES*KEY_BITS-1:0] core_key,
    output logic                          busy,
    output logic                          done,
    output logic                          found,
    output logic [KEY_BITS-1:0]           found_key,
    output logic [WW-1:0]                 winner,
    output logic [CNT_WIDTH-1:0]          cycle_count
);
    sched_state_t state, next;
    logic [NUM_CORES-1:0] term_mask;
    logic [WW-1:0] win_idx;
    logic win_valid;
    logic all_term;

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_slice
        assign core_lower[i*KEY_BITS +: KEY_BITS] = KEY_BITS'(slice_bound(i, KEY_BITS, NUM_CORES));
        assign core_upper[i*KEY_BITS +: KEY_BITS] = KEY_BITS'(slice_bound(i + 1, KEY_BITS, NUM_CORES) - 64'd1);
    end

    sched_priority_encoder #(.N(NUM_CORES)) u_prio (
        .req  (core_succeeded),
        .idx  (win_idx),
        .valid(win_valid)
    );

    assign all_term = &(term_mask | core_terminated);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = start ? CLEAR : IDLE;
            CLEAR:   next = LAUNCH;
            LAUNCH:  next = RUN;
            RUN:     next = win_valid ? KILL : all_term ? FINISH : RUN;
            KILL:    next = FINISH;
            FINISH:  next = IDLE;
            default: next = IDLE;
        endcase
    end

    assign core_reset = {NUM_CORES{reset || state == CLEAR || state == KILL}};
    assign core_start = {NUM_CORES{state == LAUNCH}};
    assign busy = state != IDLE;
    assign done = state == FINISH;

    // Success outranks the all-terminated exit when both land in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || (state == IDLE && start)) begin
            found <= 1'b0;
            found_key <= '0;
            winner <= '0;
            cycle_count <= '0;
            term_mask <= '0;
        end else begin
            if (state == LAUNCH) cycle_count <= CNT_WIDTH'(1);
            else if (state == RUN || state == KILL) cycle_count <= &cycle_count ? cycle_count : cycle_count + 1'b1;
            if (state == RUN) begin
                term_mask <= term_mask | core_terminated;
                if (win_valid) begin
                    winner <= win_idx;
                    found_key <= core_key[win_idx*KEY_BITS +: KEY_BITS];
                    found <= 1'b1;
                end else if (all_term) begin
                    found <= 1'b0;
                    found_key <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_arcfour_search_scheduler.sv
// tb_arcfour_search_scheduler: directed checks of slicing, success/termination paths,
// priority, ignored restart, mid-search reset and counter saturation.
module tb_arcfour_search_scheduler;
    localparam int NC = 4;
    localparam int KB = 22;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [NC-1:0] core_terminated = '0;
    logic [NC-1:0] core_succeeded = '0;
    logic [NC*KB-1:0] core_key = '0;
    logic [NC-1:0] core_reset, core_start, s_core_reset, s_core_start;
    logic [NC*KB-1:0] core_lower, core_upper, s_core_lower, s_core_upper;
    logic busy, done, found, s_busy, s_done, s_found;
    logic [KB-1:0] found_key, s_found_key;
    logic [1:0] winner, s_winner;
    logic [31:0] cycle_count;
    logic [3:0] s_cycle_count;

    int n_checks = 0;
    int n_fail = 0;
    int rc = 0;

    always #5 clk = ~clk;

    arcfour_search_scheduler #(.NUM_CORES(NC), .KEY_BITS(KB), .CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start),
        .core_reset(core_reset), .core_start(core_start),
        .core_lower(core_lower), .core_upper(core_upper),
        .core_terminated(core_terminated), .core_succeeded(core_succeeded), .core_key(core_key),
        .busy(busy), .done(done), .found(found), .found_key(found_key),
        .winner(winner), .cycle_count(cycle_count)
    );

    arcfour_search_scheduler #(.NUM_CORES(NC), .KEY_BITS(KB), .CNT_WIDTH(4)) dut_sat (
        .clk(clk), .reset(reset), .start(start),
        .core_reset(s_core_reset), .core_start(s_core_start),
        .core_lower(s_core_lower), .core_upper(s_core_upper),
        .core_terminated(core_terminated), .core_succeeded(core_succeeded), .core_key(core_key),
        .busy(s_busy), .done(s_done), .found(s_found), .found_key(s_found_key),
        .winner(s_winner), .cycle_count(s_cycle_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_cycle(input int n);
        while (rc < n) begin
            tick();
            rc++;
        end
    endtask

    task automatic pulse(input logic [NC-1:0] t, input logic [NC-1:0] s);
        core_terminated = t;
        core_succeeded = s;
        tick();
        rc++;
        core_terminated = '0;
        core_succeeded = '0;
    endtask

    task automatic launch();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("clear_core_reset", core_reset, 4'hF);
        check("clear_busy", busy, 1);
        check("clear_core_start", core_start, 0);
        tick();
        check("launch_core_start", core_start, 4'hF);
        check("launch_core_reset", core_reset, 0);
        tick();
        rc = 1;
        check("run_core_start", core_start, 0);
        check("run_count_start", cycle_count, 1);
    endtask

    initial begin
        tick();
        tick();
        check("reset_core_reset", core_reset, 4'hF);
        check("reset_busy", busy, 0);
        reset = 1'b0;
        #1;
        check("idle_core_reset", core_reset, 0);
        check("idle_done", done, 0);
        check("idle_found", found, 0);
        check("idle_key", found_key, 0);
        check("idle_winner", winner, 0);
        check("idle_count", cycle_count, 0);
        check("lower0", core_lower[0*KB +: KB], 22'h000000);
        check("lower1", core_lower[1*KB +: KB], 22'h100000);
        check("lower2", core_lower[2*KB +: KB], 22'h200000);
        check("lower3", core_lower[3*KB +: KB], 22'h300000);
        check("upper0", core_upper[0*KB +: KB], 22'h0FFFFF);
        check("upper3", core_upper[3*KB +: KB], 22'h3FFFFF);

        // core 2 wins on RUN cycle 50
        launch();
        goto_cycle(50);
        core_key[2*KB +: KB] = 22'h2A5F31;
        pulse(4'b0100, 4'b0100);
        check("t2_kill_reset", core_reset, 4'hF);
        check("t2_found", found, 1);
        check("t2_key", found_key, 22'h2A5F31);
        check("t2_winner", winner, 2);
        check("t2_no_done_in_kill", done, 0);
        tick();
        check("t2_done", done, 1);
        check("t2_count", cycle_count, 52);
        check("t2_sat_count", s_cycle_count, 4'hF);
        check("t2_finish_reset", core_reset, 0);
        tick();
        check("t2_done_pulse", done, 0);
        check("t2_idle_busy", busy, 0);
        check("t2_found_held", found, 1);

        // cores 1 and 3 succeed together
        launch();
        goto_cycle(3);
        core_key[1*KB +: KB] = 22'h1ABCDE;
        core_key[3*KB +: KB] = 22'h3FEDCB;
        pulse(4'b1010, 4'b1010);
        check("t3_winner", winner, 1);
        check("t3_key", found_key, 22'h1ABCDE);
        tick();
        check("t3_done", done, 1);
        check("t3_count", cycle_count, 5);
        check("t3_sat_count", s_cycle_count, 5);
        tick();

        // all four terminate without success
        launch();
        check("t4_found_cleared", found, 0);
        goto_cycle(10);
        pulse(4'b0001, 4'b0000);
        check("t4_still_busy", busy, 1);
        check("t4_no_done", done, 0);
        goto_cycle(20);
        pulse(4'b0010, 4'b0000);
        goto_cycle(30);
        pulse(4'b0100, 4'b0000);
        goto_cycle(40);
        pulse(4'b1000, 4'b0000);
        check("t4_done", done, 1);
        check("t4_found", found, 0);
        check("t4_key", found_key, 0);
        check("t4_count", cycle_count, 41);
        tick();

        // early termination, ignored restart, late success on core 3
        launch();
        goto_cycle(5);
        pulse(4'b0001, 4'b0000);
        goto_cycle(10);
        start = 1'b1;
        tick();
        rc++;
        start = 1'b0;
        check("t5_restart_busy", busy, 1);
        check("t5_restart_no_clear", core_reset, 0);
        check("t5_restart_no_launch", core_start, 0);
        goto_cycle(90);
        core_key[3*KB +: KB] = 22'h3C0FFE;
        pulse(4'b1000, 4'b1000);
        check("t5_found", found, 1);
        check("t5_winner", winner, 3);
        check("t5_key", found_key, 22'h3C0FFE);
        tick();
        check("t5_done", done, 1);
        check("t5_count", cycle_count, 92);
        tick();

        // reset mid-search, then a fresh run with pulses ignored in CLEAR/LAUNCH
        launch();
        goto_cycle(7);
        reset = 1'b1;
        tick();
        check("t6_reset_busy", busy, 0);
        check("t6_reset_found", found, 0);
        check("t6_reset_core_reset", core_reset, 4'hF);
        check("t6_reset_count", cycle_count, 0);
        reset = 1'b0;
        #1;
        check("t6_idle_core_reset", core_reset, 0);
        core_terminated = 4'hF;
        core_succeeded = 4'hF;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t6_clear_reset", core_reset, 4'hF);
        tick();
        check("t6_launch_start", core_start, 4'hF);
        tick();
        rc = 1;
        core_terminated = '0;
        core_succeeded = '0;
        check("t6_run_start_low", core_start, 0);
        tick();
        rc++;
        check("t6_ignored_busy", busy, 1);
        check("t6_ignored_done", done, 0);
        check("t6_ignored_found", found, 0);
        check("t6_ignored_reset", core_reset, 0);
        pulse(4'hF, 4'h0);
        check("t6_done", done, 1);
        check("t6_count", cycle_count, 3);
        check("t6_found", found, 0);
        tick();
        check("t6_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
